stock_price_feeder: RTL and testbench

// - Transmit side of the stock_price/data_ready interface into the averaging block.
// - Buffers prices from the upstream market-data source in a circular FIFO.
// - Emits one price per data_ready pulse, spaced so the averaging controller can

---
 rtl/stock_price_feeder_if.sv | 39 +++
 rtl/stock_price_feeder.sv | 156 +++++++++++++++
 tb/tb_stock_price_feeder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/stock_price_feeder_if.sv
// Handshake bundle between the market-data source, the price feeder and the averaging block.
// FEEDER_DROP_CNT_EN adds the drop_count observation signal.
interface stock_price_feeder_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          push_valid;
  logic [31:0]   push_price;
  logic          push_ready;
  logic          flush;
  logic [31:0]   stock_price;
  logic          data_ready;
  logic [CW-1:0] fifo_count;
  logic          busy;
`ifdef FEEDER_DROP_CNT_EN
  logic [15:0]   drop_count;
`endif

`ifdef FEEDER_DROP_CNT_EN
  modport master (
    input  push_valid, push_price, flush,
    output push_ready, stock_price, data_ready, fifo_count, busy, drop_count
  );
  modport slave (
    output push_valid, push_price, flush,
    input  push_ready, stock_price, data_ready, fifo_count, busy, drop_count
  );
`else
  modport master (
    input  push_valid, push_price, flush,
    output push_ready, stock_price, data_ready, fifo_count, busy
  );
  modport slave (
    output push_valid, push_price, flush,
    input  push_ready, stock_price, data_ready, fifo_count, busy
  );
`endif
endinterface

// File: rtl/stock_price_feeder.sv
// Paced price feeder: circular FIFO drained one word per data_ready strobe, GAP_CYCLES apart.
// Optional feature macro: FEEDER_DROP_CNT_EN (saturating count of refused pushes).
module stock_price_feeder #(
  parameter int DEPTH      = 8,
  parameter int GAP_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  stock_price_feeder_if.master bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    GAP  = 1'b1
  } state_t;

  state_t        state_r;
  state_t        state_nx;
  logic [GW-1:0] gap_cnt_r;
  logic [GW-1:0] gap_cnt_nx;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nx;
  logic [31:0]   mem_r [DEPTH];
  logic [31:0]   stock_price_r;
  logic          data_ready_r;
  logic          push_ready_r;
  logic          busy_r;
  logic          push_s;
  logic          pop_s;

  // Acceptance uses the registered ready, so a same-cycle pop never frees a slot early.
  always_comb begin
    push_s = bus.push_valid && push_ready_r;
  end

  // Pacing FSM: pop whenever idle with data, then hold off for GAP_CYCLES cycles.
  always_comb begin
    state_nx   = state_r;
    gap_cnt_nx = gap_cnt_r;
    pop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s      = 1'b1;
          gap_cnt_nx = GW'(GAP_CYCLES);
          state_nx   = GAP;
        end else begin
          state_nx   = IDLE;
        end
      end
      GAP: begin
        gap_cnt_nx = gap_cnt_r - GW'(1'b1);
        if (gap_cnt_r == GW'(1'b1)) begin
          state_nx = IDLE;
        end else begin
          state_nx = GAP;
        end
      end
      default: begin
        state_nx   = IDLE;
        gap_cnt_nx = {GW{1'b0}};
      end
    endcase
  end

  // Occupancy after this cycle's accepted push and/or pop.
  always_comb begin
    count_nx = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nx = count_r + CW'(1'b1);
      2'b01:   count_nx = count_r - CW'(1'b1);
      default: count_nx = count_r;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r   <= IDLE;
      gap_cnt_r <= {GW{1'b0}};
    end else if (bus.flush) begin
      state_r   <= IDLE;
      gap_cnt_r <= {GW{1'b0}};
    end else begin
      state_r   <= state_nx;
      gap_cnt_r <= gap_cnt_nx;
    end
  end

  // FIFO pointers, occupancy and the registered status outputs.
  always_ff @(posedge clk) begin
    if (n_rst || bus.flush) begin
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      data_ready_r <= 1'b0;
      push_ready_r <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r      <= count_nx;
      data_ready_r <= pop_s;
      push_ready_r <= (count_nx != CW'(DEPTH));
      busy_r       <= (state_nx == GAP) || (count_nx != {CW{1'b0}});
    end
  end

  // Output price: cleared only by reset; flush leaves the last sample visible.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      stock_price_r <= 32'd0;
    end else if (!bus.flush && pop_s) begin
      stock_price_r <= mem_r[rd_ptr_r];
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!n_rst && !bus.flush && push_s) begin
      mem_r[wr_ptr_r] <= bus.push_price;
    end
  end

`ifdef FEEDER_DROP_CNT_EN
  logic [15:0] drop_count_r;

  // Saturating count of cycles where upstream offered a word that could not be taken.
  always_ff @(posedge clk) begin
    if (n_rst || bus.flush) begin
      drop_count_r <= 16'd0;
    end else if (bus.push_valid && !push_ready_r && (drop_count_r != 16'hFFFF)) begin
      drop_count_r <= drop_count_r + 16'd1;
    end
  end

  assign bus.drop_count = drop_count_r;
`endif

  assign bus.stock_price = stock_price_r;
  assign bus.data_ready  = data_ready_r;
  assign bus.push_ready  = push_ready_r;
  assign bus.fifo_count  = count_r;
  assign bus.busy        = busy_r;

endmodule

// File: tb/tb_stock_price_feeder.sv
// Directed scoreboard bench for stock_price_feeder (DEPTH=8, GAP_CYCLES=4).
module tb_stock_price_feeder;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;

  always #5 clk = ~clk;

  stock_price_feeder_if #(.DEPTH(DEPTH)) bus ();

  stock_price_feeder #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.master)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [31:0] exp_q[$];
  int          pulse_q[$];
  logic        prev_dr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic acc);
    bus.push_valid = 1'b1;
    bus.push_price = p;
    chk("push_ready", {31'd0, bus.push_ready}, {31'd0, acc});
    if (acc) exp_q.push_back(p);
    tick();
    bus.push_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk(tag, 32'(exp_q.size()), 32'd0);
    repeat (GAP + 2) tick();
    chk({tag, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
  endtask

  // Output monitor: every strobe must match the scoreboard head and last one cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!n_rst && bus.data_ready === 1'b1) begin
        chk("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("price_order", bus.stock_price, exp_q.pop_front());
        chk("pulse_width", {31'd0, prev_dr}, 32'd0);
        pulse_q.push_back(cyc);
      end
      prev_dr = bus.data_ready;
    end
  end

  initial begin
    bus.push_valid = 1'b0;
    bus.push_price = 32'd0;
    bus.flush      = 1'b0;
    n_rst          = 1'b1;
    tick();
    tick();
    chk("rst_data_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("rst_stock_price", bus.stock_price, 32'd0);
    chk("rst_push_ready", {31'd0, bus.push_ready}, 32'd1);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
`ifdef FEEDER_DROP_CNT_EN
    chk("rst_drop_count", 32'(bus.drop_count), 32'd0);
`endif
    n_rst = 1'b0;

    // Single push: strobe one cycle after acceptance, then one cycle wide.
    push(32'd1500, 1'b1);
    chk("single_count", 32'(bus.fifo_count), 32'd1);
    chk("single_dr_early", {31'd0, bus.data_ready}, 32'd0);
    tick();
    chk("single_dr", {31'd0, bus.data_ready}, 32'd1);
    chk("single_price", bus.stock_price, 32'd1500);
    chk("single_busy", {31'd0, bus.busy}, 32'd1);
    tick();
    chk("single_dr_low", {31'd0, bus.data_ready}, 32'd0);
    drain("single_drain");

    // Burst of 8: strobes exactly GAP+1 cycles apart.
    pulse_q.delete();
    for (int i = 0; i < 8; i++) push(32'd100 + 32'(i), 1'b1);
    drain("burst_drain");
    chk("burst_pulses", 32'(pulse_q.size()), 32'd8);
    if (pulse_q.size() == 8) begin
      for (int i = 1; i < 8; i++) chk("burst_spacing", 32'(pulse_q[i] - pulse_q[i-1]), 32'(GAP + 1));
    end
    chk("burst_count", 32'(bus.fifo_count), 32'd0);

    // Fill to DEPTH while output is paced; the next offer is refused.
    for (int i = 0; i < 10; i++) push(32'd200 + 32'(i), 1'b1);
    chk("full_count", 32'(bus.fifo_count), 32'd8);
    push(32'd299, 1'b0);
`ifdef FEEDER_DROP_CNT_EN
    chk("drop_count", 32'(bus.drop_count), 32'd1);
`endif
    drain("full_drain");

    // Two refills of 6 to carry the pointers across the wrap point.
    for (int i = 0; i < 6; i++) push(32'd300 + 32'(i), 1'b1);
    drain("wrap_drain_a");
    for (int i = 6; i < 12; i++) push(32'd300 + 32'(i), 1'b1);
    drain("wrap_drain_b");

    // Flush with a concurrent push on the cycle after a strobe.
    for (int i = 0; i < 5; i++) push(32'd400 + 32'(i), 1'b1);
    tick();
    tick();
    chk("pre_flush_dr", {31'd0, bus.data_ready}, 32'd1);
    chk("pre_flush_count", 32'(bus.fifo_count), 32'd3);
    chk("pre_flush_price", bus.stock_price, 32'd401);
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_price = 32'd999;
    tick();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    exp_q.delete();
    chk("flush_count", 32'(bus.fifo_count), 32'd0);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_dr", {31'd0, bus.data_ready}, 32'd0);
    chk("flush_price_hold", bus.stock_price, 32'd401);
    chk("flush_push_ready", {31'd0, bus.push_ready}, 32'd1);
`ifdef FEEDER_DROP_CNT_EN
    chk("flush_drop_count", 32'(bus.drop_count), 32'd0);
`endif
    repeat (10) tick();
    chk("post_flush_price", bus.stock_price, 32'd401);
    chk("post_flush_count", 32'(bus.fifo_count), 32'd0);

    // Reset in the middle of a gap with 5 words buffered.
    for (int i = 0; i < 7; i++) push(32'd500 + 32'(i), 1'b1);
    chk("midgap_dr", {31'd0, bus.data_ready}, 32'd1);
    chk("midgap_count", 32'(bus.fifo_count), 32'd5);
    tick();
    chk("midgap_busy", {31'd0, bus.busy}, 32'd1);
    n_rst = 1'b1;
    tick();
    exp_q.delete();
    chk("rst2_data_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("rst2_stock_price", bus.stock_price, 32'd0);
    chk("rst2_push_ready", {31'd0, bus.push_ready}, 32'd1);
    chk("rst2_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst2_fifo_count", 32'(bus.fifo_count), 32'd0);
    n_rst = 1'b0;
    push(32'd777, 1'b1);
    tick();
    chk("rst2_single_dr", {31'd0, bus.data_ready}, 32'd1);
    chk("rst2_single_price", bus.stock_price, 32'd777);
    drain("final_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
